multi_channel_silence_detector: RTL and testbench
=================================================

// Module: multi_channel_silence_detector
// PURPOSE
//  Parametrised N-channel silence detector with sleep/wake state machine for the MSDAP input path.
//  Counts consecutive "quiet" samples per channel; a quiet sample is a signed value within +/-ZERO_TOL.
//  Enters SLEEP when every channel has seen ZERO_LIMIT consecutive quiet samples.
//  Wakes on the first non-quiet sample on any channel.
//  Sits between the serial sample deserialiser and the filter core; the core gates off computation while sleep=1.
// PARAMETERS
//  NUM_CH      2    number of channels, >=1
//  DATA_W      16   sample width, two's complement
//  ZERO_LIMIT  800  consecutive quiet samples required per channel, >=1
//  ZERO_TOL    0    quiet band magnitude, 0 = exact zero only; must be < 2**(DATA_W-1)
//  CNT_W       $clog2(ZERO_LIMIT+1)  counter width (derived localparam, not overridable)
// PORTS
//  clk           in   1               system clock, all logic on posedge
//  clear_n       in   1               synchronous active-low reset
//  sample_valid  in   1               one-cycle strobe: data_in holds a new sample set
//  data_in       in   NUM_CH*DATA_W   packed samples, ch0 in [DATA_W-1:0]
//  sleep         out  1               1 while FSM in SLEEP
//  sleep_enter   out  1               1-cycle pulse on ACTIVE->SLEEP
//  sleep_exit    out  1               1-cycle pulse on SLEEP->ACTIVE
//  ch_zero       out  NUM_CH          bit i = channel i counter saturated at ZERO_LIMIT
//  zero_count    out  NUM_CH*CNT_W    packed per-channel counters, ch0 at LSBs
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous, active-low (clear_n), sampled on posedge clk.
//  - Reset (clear_n=0 at an edge, including mid-count or in SLEEP):
//    counters=0, ch_zero=0, state=ACTIVE, sleep=0, sleep_enter=0, sleep_exit=0. Reset overrides sample_valid.
//  - All outputs are registered. Update is visible the cycle after the sample_valid edge (latency 1).
//  - Quiet test per channel is a signed compare: -ZERO_TOL <= x <= ZERO_TOL.
//    No abs(), so x = -2**(DATA_W-1) is never quiet.
//  - Per channel, on sample_valid:
//    - quiet: cnt <= (cnt==ZERO_LIMIT) ? ZERO_LIMIT : cnt+1, saturating, no wrap.
//    - non-quiet: cnt <= 0.
//    - Channels update independently in the same cycle.
//  - ch_zero[i] <= (next cnt_i == ZERO_LIMIT). It asserts with the ZERO_LIMIT-th consecutive quiet sample.
//  - sample_valid=0: counters, ch_zero and state hold; sleep_enter/sleep_exit drive 0.
//  - FSM, 2 states:
//    - ACTIVE -> SLEEP: on a sample_valid where the next ch_zero is all ones. sleep_enter=1 for that one cycle.
//    - SLEEP -> ACTIVE: on a sample_valid where any channel is non-quiet. sleep_exit=1 for one cycle.
//      Only the offending channels' counters clear; quiet channels stay saturated.
//    - SLEEP with all channels quiet: stay; counters stay at ZERO_LIMIT.
//  - sleep_enter and sleep_exit are never both 1.
//  - ZERO_LIMIT=1: a single all-quiet sample set enters SLEEP.
// TESTING
//  1. Defaults, 799 valid all-zero sets -> sleep=0, ch_zero=2'b11 not yet set.
//     800th set -> next cycle sleep=1, sleep_enter=1 for exactly 1 cycle, zero_count={800,800}.
//  2. In SLEEP, send ch0=0, ch1=16'h0001 -> next cycle sleep=0, sleep_exit pulse,
//     ch_zero=2'b01, ch1 count=0, ch0 count=800.
//  3. ZERO_TOL=2: alternating +2/-2 for 800 sets -> sleep=1.
//     Then -3 -> wake. Separately, 16'h8000 -> counter reset, never quiet.
//  4. 400 zero sets, idle 50 cycles with sample_valid=0, then 400 more -> counts hold during the gap;
//     sleep asserts after set 800 total.
//  5. clear_n=0 for one edge at count 500 (and again while in SLEEP) -> all counts 0, sleep=0, no pulses.
//     A full 800 sets are needed afterwards.
//  6. Staggered: ch0 nonzero at set 100 of a zero run -> ch1 saturates at set 800 (ch_zero=2'b10), sleep=0.
//     sleep asserts at set 900.

Source files
------------

// File: rtl/multi_channel_silence_detector_if.sv
// ---------------------------------------------------------------------------
// multi_channel_silence_detector_if
//
// Purpose:
//   Bundles the sample input and the sleep/wake status outputs of the
//   multi-channel silence detector into one interface. The deserialiser
//   side (master) presents sample sets; the detector (slave) returns its
//   registered status.
//
// Parameters:
//   NUM_CH      number of channels
//   DATA_W      sample width, two's complement
//   ZERO_LIMIT  saturation value of the per-channel quiet counters
//   CNT_W       derived counter width, $clog2(ZERO_LIMIT+1)
//
// Signals:
//   sample_valid  master->slave  one-cycle strobe, data_in holds a new set
//   data_in       master->slave  packed samples, ch0 in [DATA_W-1:0]
//   sleep         slave->master  1 while the detector is asleep
//   sleep_enter   slave->master  1-cycle pulse on ACTIVE->SLEEP
//   sleep_exit    slave->master  1-cycle pulse on SLEEP->ACTIVE
//   ch_zero       slave->master  bit i = channel i counter saturated
//   zero_count    slave->master  packed per-channel counters, ch0 at LSBs
// ---------------------------------------------------------------------------
interface multi_channel_silence_detector_if #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 16,
  parameter int ZERO_LIMIT = 800
);

  localparam int CNT_W = $clog2(ZERO_LIMIT + 1);

  logic                      sample_valid;
  logic [NUM_CH*DATA_W-1:0]  data_in;
  logic                      sleep;
  logic                      sleep_enter;
  logic                      sleep_exit;
  logic [NUM_CH-1:0]         ch_zero;
  logic [NUM_CH*CNT_W-1:0]   zero_count;

  modport master (
    output sample_valid,
    output data_in,
    input  sleep,
    input  sleep_enter,
    input  sleep_exit,
    input  ch_zero,
    input  zero_count
  );

  modport slave (
    input  sample_valid,
    input  data_in,
    output sleep,
    output sleep_enter,
    output sleep_exit,
    output ch_zero,
    output zero_count
  );

endinterface

// File: rtl/multi_channel_silence_detector.sv
// ---------------------------------------------------------------------------
// multi_channel_silence_detector
//
// Purpose:
//   N-channel silence detector for the MSDAP input path. Each channel keeps
//   a saturating count of consecutive quiet samples (signed value within
//   +/-ZERO_TOL). When every channel has seen ZERO_LIMIT consecutive quiet
//   samples the detector goes to SLEEP so the filter core can stop
//   computing; the first non-quiet sample on any channel wakes it again.
//
// Parameters:
//   NUM_CH      number of channels, >= 1
//   DATA_W      sample width, two's complement
//   ZERO_LIMIT  consecutive quiet samples required per channel, >= 1
//   ZERO_TOL    quiet band magnitude, 0 = exact zero only
//
// Ports:
//   clk      in   system clock, everything on posedge
//   clear_n  in   synchronous active-low reset
//   bus      slave modport of multi_channel_silence_detector_if carrying
//            sample_valid/data_in in and sleep, sleep_enter, sleep_exit,
//            ch_zero, zero_count out (all outputs registered, latency 1)
// ---------------------------------------------------------------------------
module multi_channel_silence_detector #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 16,
  parameter int ZERO_LIMIT = 800,
  parameter int ZERO_TOL   = 0
) (
  input  logic                                clk,
  input  logic                                clear_n,
  multi_channel_silence_detector_if.slave     bus
);

  localparam int CNT_W = $clog2(ZERO_LIMIT + 1);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(ZERO_LIMIT);

  // Quiet band bounds as signed DATA_W values. The band is tested with two
  // signed compares rather than abs(), so the most negative code is never
  // quiet (its magnitude cannot be represented).
  localparam logic signed [DATA_W-1:0] TOL_P = DATA_W'(ZERO_TOL);
  localparam logic signed [DATA_W-1:0] TOL_N = DATA_W'(-ZERO_TOL);

  typedef enum logic {
    ACTIVE = 1'b0,
    SLEEP  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic              enter_q;
  logic              exit_q;
  logic              enter_next;
  logic              exit_next;

  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic [CNT_W-1:0]  cnt_next [NUM_CH];
  logic [NUM_CH-1:0] ch_zero_q;
  logic [NUM_CH-1:0] zero_next;
  logic [NUM_CH-1:0] quiet;

  logic signed [DATA_W-1:0] sample [NUM_CH];

  // Per-channel datapath: quiet test, saturating next count, and the
  // saturation flag that the register and the FSM both look at.
  genvar g;
  for (g = 0; g < NUM_CH; g++) begin : g_ch
    assign sample[g]    = bus.data_in[g*DATA_W +: DATA_W];
    assign quiet[g]     = (sample[g] >= TOL_N) && (sample[g] <= TOL_P);
    assign cnt_next[g]  = !quiet[g]              ? '0 :
                          (cnt[g] == LIMIT_C)    ? LIMIT_C :
                                                   cnt[g] + CNT_W'(1);
    assign zero_next[g] = (cnt_next[g] == LIMIT_C);
    assign bus.zero_count[g*CNT_W +: CNT_W] = cnt[g];
  end

  // Counters and saturation flags only move on a valid sample set; reset
  // wins over sample_valid.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
      end
      ch_zero_q <= '0;
    end else if (bus.sample_valid) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= cnt_next[i];
      end
      ch_zero_q <= zero_next;
    end
  end

  // State register plus the registered one-cycle transition pulses.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state   <= ACTIVE;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
    end else begin
      state   <= state_next;
      enter_q <= enter_next;
      exit_q  <= exit_next;
    end
  end

  // Sleep is entered from the post-update saturation flags, so the set that
  // saturates the last channel is the one that puts the block to sleep.
  // Wake uses the raw quiet test: any loud channel on a valid set wakes,
  // and only that channel's counter is cleared by the datapath above.
  always_comb begin
    state_next = state;
    enter_next = 1'b0;
    exit_next  = 1'b0;
    if (bus.sample_valid) begin
      case (state)
        ACTIVE: begin
          if (&zero_next) begin
            state_next = SLEEP;
            enter_next = 1'b1;
          end
        end
        SLEEP: begin
          if (!(&quiet)) begin
            state_next = ACTIVE;
            exit_next  = 1'b1;
          end
        end
        default: begin
          state_next = ACTIVE;
        end
      endcase
    end
  end

  assign bus.sleep       = (state == SLEEP);
  assign bus.sleep_enter = enter_q;
  assign bus.sleep_exit  = exit_q;
  assign bus.ch_zero     = ch_zero_q;

endmodule

// File: tb/tb_multi_channel_silence_detector.sv
// ---------------------------------------------------------------------------
// tb_multi_channel_silence_detector
//
// Three detector instances share clock and reset:
//   dut0  defaults (ZERO_LIMIT=800, ZERO_TOL=0)
//   dut1  ZERO_TOL=2
//   dut2  ZERO_LIMIT=1
// Every driven cycle pushes the hand-computed expected outputs of each
// instance into its queue; a monitor pops one entry per instance after
// each rising edge and compares it with the registered outputs.
// ---------------------------------------------------------------------------
module tb_multi_channel_silence_detector;

  typedef struct packed {
    logic        sleep;
    logic        enter;
    logic        leave;
    logic [1:0]  ch_zero;
    logic [15:0] c0;
    logic [15:0] c1;
  } obs_t;

  logic clk;
  logic clear_n;

  int   errors;
  int   checks;

  obs_t exp_q [3][$];
  obs_t last  [3];

  multi_channel_silence_detector_if #(.NUM_CH(2), .DATA_W(16), .ZERO_LIMIT(800)) if0 ();
  multi_channel_silence_detector_if #(.NUM_CH(2), .DATA_W(16), .ZERO_LIMIT(800)) if1 ();
  multi_channel_silence_detector_if #(.NUM_CH(2), .DATA_W(16), .ZERO_LIMIT(1))   if2 ();

  multi_channel_silence_detector #(.NUM_CH(2), .DATA_W(16), .ZERO_LIMIT(800), .ZERO_TOL(0)) dut0 (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (if0)
  );

  multi_channel_silence_detector #(.NUM_CH(2), .DATA_W(16), .ZERO_LIMIT(800), .ZERO_TOL(2)) dut1 (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (if1)
  );

  multi_channel_silence_detector #(.NUM_CH(2), .DATA_W(16), .ZERO_LIMIT(1), .ZERO_TOL(0)) dut2 (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input bit s, input bit en, input bit ex,
                              input bit [1:0] cz, input int c0, input int c1);
    obs_t o;
    o.sleep   = s;
    o.enter   = en;
    o.leave   = ex;
    o.ch_zero = cz;
    o.c0      = 16'(c0);
    o.c1      = 16'(c1);
    return o;
  endfunction

  function automatic obs_t read_dut(input int d);
    obs_t o;
    o = '0;
    case (d)
      0: begin
        o.sleep = if0.sleep; o.enter = if0.sleep_enter; o.leave = if0.sleep_exit;
        o.ch_zero = if0.ch_zero;
        o.c0 = 16'(if0.zero_count[9:0]); o.c1 = 16'(if0.zero_count[19:10]);
      end
      1: begin
        o.sleep = if1.sleep; o.enter = if1.sleep_enter; o.leave = if1.sleep_exit;
        o.ch_zero = if1.ch_zero;
        o.c0 = 16'(if1.zero_count[9:0]); o.c1 = 16'(if1.zero_count[19:10]);
      end
      default: begin
        o.sleep = if2.sleep; o.enter = if2.sleep_enter; o.leave = if2.sleep_exit;
        o.ch_zero = if2.ch_zero;
        o.c0 = 16'(if2.zero_count[0]); o.c1 = 16'(if2.zero_count[1]);
      end
    endcase
    return o;
  endfunction

  // Drives one cycle. Instance d gets (sv, data) and expectation e; the other
  // instances are idle with junk data and must hold with pulses low. A reset
  // cycle clears every instance.
  task automatic apply_stimulus(input int d, input bit rst, input bit sv,
                                input logic [31:0] data, input obs_t e);
    obs_t x;
    @(negedge clk);
    clear_n          = !rst;
    if0.sample_valid = (d == 0) && sv;
    if1.sample_valid = (d == 1) && sv;
    if2.sample_valid = (d == 2) && sv;
    if0.data_in      = (d == 0) ? data : 32'hA5A5_5A5A;
    if1.data_in      = (d == 1) ? data : 32'h8000_1234;
    if2.data_in      = (d == 2) ? data : 32'h0001_0001;
    for (int k = 0; k < 3; k++) begin
      if (k == d) begin
        x = e;
      end else if (rst) begin
        x = '0;
      end else begin
        x = last[k];
        x.enter = 1'b0;
        x.leave = 1'b0;
      end
      exp_q[k].push_back(x);
      last[k] = x;
    end
  endtask

  task automatic do_reset();
    apply_stimulus(0, 1'b1, 1'b1, 32'hFFFF_0007, mk(0, 0, 0, 2'b00, 0, 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(3, 1'b0, 1'b0, 32'h0, '0);
    end
  endtask

  // Monitor: one registered result per instance appears after each edge.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        if (exp_q[d].size() > 0) begin
          e = exp_q[d].pop_front();
          a = read_dut(d);
          checks++;
          if (a !== e) begin
            errors++;
            $display("[TB] FAIL dut%0d_outputs @%0t: got sleep=%0b enter=%0b exit=%0b ch_zero=%b cnt0=%0d cnt1=%0d, expected sleep=%0b enter=%0b exit=%0b ch_zero=%b cnt0=%0d cnt1=%0d",
                     d, $time, a.sleep, a.enter, a.leave, a.ch_zero, a.c0, a.c1,
                     e.sleep, e.enter, e.leave, e.ch_zero, e.c0, e.c1);
          end
        end
      end
    end
  end

  initial begin
    errors  = 0;
    checks  = 0;
    clear_n = 1'b0;
    if0.sample_valid = 1'b0; if0.data_in = '0;
    if1.sample_valid = 1'b0; if1.data_in = '0;
    if2.sample_valid = 1'b0; if2.data_in = '0;
    for (int k = 0; k < 3; k++) last[k] = '0;

    do_reset();
    do_reset();

    // dut1, tolerance 2: alternating +2/-2 is quiet, -3/+3 and 0x8000 are not.
    $display("[TB] tolerance band on dut1");
    for (int i = 1; i <= 800; i++) begin
      apply_stimulus(1, 1'b0, 1'b1, (i % 2 == 0) ? 32'hFFFE_0002 : 32'h0002_FFFE,
                     mk(i == 800, i == 800, 0, (i == 800) ? 2'b11 : 2'b00, i, i));
    end
    apply_stimulus(1, 1'b0, 1'b1, 32'h0000_FFFD, mk(0, 0, 1, 2'b10, 0, 800));
    apply_stimulus(1, 1'b0, 1'b1, 32'h0003_0002, mk(0, 0, 0, 2'b00, 1, 0));
    apply_stimulus(1, 1'b0, 1'b1, 32'h8000_FFFE, mk(0, 0, 0, 2'b00, 2, 0));
    apply_stimulus(1, 1'b0, 1'b1, 32'h0001_0000, mk(0, 0, 0, 2'b00, 3, 1));

    // dut2, limit 1: a single all-quiet set sleeps.
    $display("[TB] single-sample limit on dut2");
    apply_stimulus(2, 1'b0, 1'b1, 32'h0000_0000, mk(1, 1, 0, 2'b11, 1, 1));
    apply_stimulus(2, 1'b0, 1'b1, 32'h0000_0000, mk(1, 0, 0, 2'b11, 1, 1));
    apply_stimulus(2, 1'b0, 1'b1, 32'h0000_0001, mk(0, 0, 1, 2'b10, 0, 1));
    idle(1);
    apply_stimulus(2, 1'b0, 1'b1, 32'h0000_0000, mk(1, 1, 0, 2'b11, 1, 1));
    apply_stimulus(2, 1'b0, 1'b1, 32'h8000_0000, mk(0, 0, 1, 2'b01, 1, 0));

    // dut0: 400 sets, 50 idle cycles, 400 more sets.
    $display("[TB] gap hold on dut0");
    for (int i = 1; i <= 400; i++) begin
      apply_stimulus(0, 1'b0, 1'b1, 32'h0, mk(0, 0, 0, 2'b00, i, i));
    end
    idle(50);
    for (int i = 401; i <= 800; i++) begin
      apply_stimulus(0, 1'b0, 1'b1, 32'h0, mk(i == 800, i == 800, 0, (i == 800) ? 2'b11 : 2'b00, i, i));
    end

    // Reset while asleep, then reset at count 500, then a full 800-set run.
    $display("[TB] resets and full run on dut0");
    do_reset();
    for (int i = 1; i <= 500; i++) begin
      apply_stimulus(0, 1'b0, 1'b1, 32'h0, mk(0, 0, 0, 2'b00, i, i));
    end
    do_reset();
    for (int i = 1; i <= 800; i++) begin
      apply_stimulus(0, 1'b0, 1'b1, 32'h0, mk(i == 800, i == 800, 0, (i == 800) ? 2'b11 : 2'b00, i, i));
    end
    idle(1);
    apply_stimulus(0, 1'b0, 1'b1, 32'h0, mk(1, 0, 0, 2'b11, 800, 800));

    // Wake on ch1=1: only ch1 clears.
    apply_stimulus(0, 1'b0, 1'b1, 32'h0001_0000, mk(0, 0, 1, 2'b01, 800, 0));
    idle(2);
    apply_stimulus(0, 1'b0, 1'b1, 32'h0000_8000, mk(0, 0, 0, 2'b00, 0, 1));

    // Staggered: ch0 loud at set 100, ch1 saturates at 800, sleep at 900.
    $display("[TB] staggered channels on dut0");
    do_reset();
    for (int i = 1; i <= 900; i++) begin
      int c0;
      int c1;
      c0 = (i < 100) ? i : i - 100;
      c1 = (i < 800) ? i : 800;
      apply_stimulus(0, 1'b0, 1'b1, (i == 100) ? 32'h0000_0005 : 32'h0,
                     mk(i == 900, i == 900, 0, {i >= 800, i == 900}, c0, c1));
    end
    apply_stimulus(0, 1'b0, 1'b0, 32'hFFFF_FFFF, mk(1, 0, 0, 2'b11, 800, 800));

    // Drain the scoreboard with a bounded wait.
    idle(1);
    repeat (3) @(posedge clk);
    #2;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (exp_q[d].size() != 0) begin
        errors++;
        $display("[TB] FAIL dut%0d_drain: %0d entries left, required 0", d, exp_q[d].size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
